pipe_hazard_ctrl: RTL

- Stall/flush controller for the 5-stage ARM pipeline; it is the control-side counterpart of the ID/EX register.
- Reads decode-stage operand usage, and the EX-stage control fields the ID/EX register delivers: ex_reg_write_enable, ex_mem_to_reg_select, ex_rd.
- Drives the stall enables and flush (bubble) controls into the IF/ID, ID/EX and EX/MEM registers.
- Handles load-use hazards, taken-branch squashes, and multi-cycle data-memory waits with a timeout.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/hazard_stat_cnt.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, register
// address width and the load-use compare.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    // A decode operand depends on a load still sitting in EX.
    function automatic logic lu_hazard_f(
        input logic [REG_ADDR_W-1:0] rn,
        input logic [REG_ADDR_W-1:0] rm,
        input logic                  uses_rn,
        input logic                  uses_rm,
        input logic                  ex_we,
        input logic                  ex_load,
        input logic [REG_ADDR_W-1:0] rd
    );
        return ex_we & ex_load & ((uses_rn & (rn == rd)) | (uses_rm & (rm == rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX/MEM status toward the hazard controller and the stall/flush
// controls it returns; master is the pipeline side, slave the controller.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
();
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic                  id_uses_rn;
    logic                  id_uses_rm;
    logic                  ex_reg_write_enable;
    logic                  ex_mem_to_reg_select;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ack;
    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  mem_timeout;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm,
               ex_reg_write_enable, ex_mem_to_reg_select, ex_rd,
               ex_branch_taken, mem_req, mem_ack,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm,
               ex_reg_write_enable, ex_mem_to_reg_select, ex_rd,
               ex_branch_taken, mem_req, mem_ack,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout
    );
endinterface

// File: rtl/hazard_stat_cnt.sv
// Saturating event counter; counts one per cycle with inc_i high, holds at all-ones.
// Built only with HAZARD_STATS_EN, the only configuration that instantiates it.
`ifdef HAZARD_STATS_EN
module hazard_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, taken-branch squash, memory-wait hold
// with timeout. Mealy outputs, zero latency. HAZARD_STATS_EN adds saturating stats.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int MEM_TIMEOUT    = 64
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    , output logic [CNT_W-1:0] lu_stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
    , output logic [CNT_W-1:0] mem_wait_cnt
`endif
);
    localparam int LU_W = 2;
    localparam int WT_W = $clog2(MEM_TIMEOUT);

    ctrl_state_e     state_q, state_d;
    logic [LU_W-1:0] cnt_q, cnt_d;
    logic [WT_W-1:0] wait_q, wait_d;

    logic mem_wait, timeout, hazard, lu_act;
    logic stall_f_c, stall_d_c, stall_e_c, stall_m_c, flush_d_c, flush_e_c, timeout_c;

    assign mem_wait = hz.mem_req & ~hz.mem_ack;
    assign timeout  = mem_wait & (wait_q == WT_W'(MEM_TIMEOUT - 1));
    assign hazard   = lu_hazard_f(hz.id_rn, hz.id_rm, hz.id_uses_rn, hz.id_uses_rm,
                                  hz.ex_reg_write_enable, hz.ex_mem_to_reg_select, hz.ex_rd);
    assign lu_act   = (state_q == LU_STALL) | hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = '0;
        if (timeout) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (mem_wait) begin
            // cnt_q is held so an interrupted load-use stall can resume afterwards
            state_d = MEM_WAIT;
            wait_d  = wait_q + WT_W'(1);
        end else if (hz.ex_branch_taken) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == LU_STALL) begin
            cnt_d   = cnt_q - LU_W'(1);
            state_d = (cnt_q == LU_W'(1)) ? RUN : LU_STALL;
        end else if ((state_q == MEM_WAIT) && (cnt_q != '0)) begin
            state_d = LU_STALL;
        end else if (hazard && (LOAD_USE_STALL > 1)) begin
            state_d = LU_STALL;
            cnt_d   = LU_W'(LOAD_USE_STALL - 1);
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        stall_m_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        timeout_c = 1'b0;
        if (reset_n) begin
            if (timeout) begin
                timeout_c = 1'b1;
            end else if (mem_wait) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                stall_m_c = 1'b1;
            end else if (hz.ex_branch_taken) begin
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
            end else if (lu_act) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
            end
        end
    end

    assign hz.stall_f     = stall_f_c;
    assign hz.stall_d     = stall_d_c;
    assign hz.stall_e     = stall_e_c;
    assign hz.stall_m     = stall_m_c;
    assign hz.flush_d     = flush_d_c;
    assign hz.flush_e     = flush_e_c;
    assign hz.mem_timeout = timeout_c;

`ifdef HAZARD_STATS_EN
    hazard_stat_cnt #(.W(CNT_W)) u_lu_cnt (
        .clk(clk), .reset_n(reset_n),
        .inc_i(stall_f_c & flush_e_c), .cnt_o(lu_stall_cnt)
    );
    hazard_stat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset_n(reset_n),
        .inc_i(flush_d_c), .cnt_o(flush_cnt)
    );
    hazard_stat_cnt #(.W(CNT_W)) u_mem_cnt (
        .clk(clk), .reset_n(reset_n),
        .inc_i(stall_m_c), .cnt_o(mem_wait_cnt)
    );
`endif
endmodule
